posit_align_add: RTL and testbench
==================================

Name: posit_align_add

Overview:
- Pipelined arithmetic core of the posit adder, directly downstream of the field-extraction stage.
- Consumes the decoded fields of two operands: sign, effective exponent {regime,exp}, hidden-bit mantissa with 3 guard zeros.
- Aligns the operands, adds or subtracts them, normalises the result and presents sign/exponent/mantissa to the downstream posit encoder/rounder.
- Two-stage pipeline with valid/ready handshake on both sides.

Parameters:
- N, 8, posit word width.
- es, 4, exponent field width.
- Bs, log2(N), regime count width; same derivation as the extractor.
- EW, Bs+es+1, input effective-exponent width (signed).
- MW, N-es+3, mantissa width; MSB is the hidden 1, low 3 bits are guard.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  core can accept a pair this cycle.
- a_sin, b_sin  in  1 each  operand signs.
- a_eff_e, b_eff_e  in  EW each  signed effective exponents.
- a_mant, b_mant  in  MW each  mantissas, MSB=1.
- a_zero, b_zero, a_nar, b_nar  in  1 each  special-value flags from extraction.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sign  out  1  result sign.
- out_eff_e  out  EW+2  signed result exponent, unsaturated.
- out_mant  out  MW  normalised mantissa, MSB=1 unless zero/NaR.
- out_sticky  out  1  OR of all bits lost in alignment or normalisation.
- out_zero, out_nar  out  1 each  special results.

Behaviour:
- Reset: all pipeline valids clear, all out_* registers 0, in_ready=1 after reset release. Reset is asynchronous and may be asserted mid-transaction; in-flight data is discarded and no out_valid pulse follows.
- Transfer occurs when valid&&ready on a port.
- Stall rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no bubble on continuous flow).
  - Throughput 1/cycle; latency 2 cycles, accept edge to out_valid.
  - Output fields are held stable while out_valid && !out_ready.
- Stage 1 (swap/align), registered:
  - L = operand with larger (eff_e, mant), compared as an unsigned pair; ties pick a. S = the other operand.
  - d = L.eff_e - S.eff_e, computed EW+1 wide and non-negative.
  - S.mant is shifted right by min(d, MW+1); shifted-out bits OR into sticky1.
  - Registers op_sub = a_sin ^ b_sin and sign = L.sin.
- Stage 2 (add/normalise), registered to out_*:
  - Sum is MW+1 wide: L.mant ± S_aligned.
  - Carry out (bit MW set): shift right 1, exponent+1, the dropped LSB ORs into sticky.
  - Otherwise lz = leading zeros of sum[MW-1:0]; shift left lz, exponent - lz.
  - Sum == 0 with sticky1 == 0 gives out_zero=1, out_sign=0, out_eff_e=0, out_mant=0.
- Specials, priority high to low:
  - Any NaR: out_nar=1, other fields 0.
  - Both zero: out_zero=1.
  - One zero: result equals the other operand unchanged, sticky 0.
- out_eff_e range is -(2^(EW-1)+MW) .. 2^(EW-1); EW+2 bits signed. No saturation here; the encoder saturates.

Optional Feature:
- POSIT_ADD_STICKY_EN defined: sticky is tracked through both stages as above.
- Undefined: shifted-out bits are dropped; out_sticky is tied to 0; zero detection uses sum == 0 only.

Decomposition:
- Package posit_add_pkg holds:
  - the log2 constant function;
  - EW/MW derivation functions;
  - typedef posit_fields_t {sin, eff_e, mant, zero, nar} used by extractor, this core and the encoder;
  - typedef stage1_t for the pipeline register.
- One sub-module, posit_lzc: parameterised combinational leading-zero counter (width MW, output clog2(MW+1)).

Test Plan:
All cases use N=8, es=4, MW=7, mant 1.0 = 7'b1000000.
- 1.0+1.0: a=b={0,e=0,1000000} -> out_sign=0, out_eff_e=1, out_mant=1000000, sticky=0; out_valid exactly 2 cycles after accept.
- 4.0+1.0: a e=2, b e=0 -> out_eff_e=2, out_mant=1010000.
- 1.0+(-1.0): -> out_zero=1, out_sign=0; and 1.5-1.0 (a mant 1100000) -> out_eff_e=-1, out_mant=1000000.
- Large gap: a e=20, b e=0, opposite signs -> out_mant=1000000, out_eff_e=20, out_sign=a_sin; out_sticky=1 with POSIT_ADD_STICKY_EN, 0 without.
- Backpressure: stream 4 pairs, hold out_ready=0 for 3 cycles -> in_ready drops once both stages are full, outputs stable, no loss or duplication, order preserved.
- Specials and reset:
  - a_nar with b arbitrary -> out_nar=1.
  - b_zero -> result equals a.
  - Assert rst_n low with 2 pairs in flight -> all out_* read 0 immediately; no out_valid until new input.

Source files
------------

// File: rtl/posit_add_pkg.sv
// Shared types and width derivations for the posit adder pipeline (extractor, align/add core, encoder).
package posit_add_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned calc_ew(input int unsigned n, input int unsigned es);
    return clog2(n) + es + 1;
  endfunction

  function automatic int unsigned calc_mw(input int unsigned n, input int unsigned es);
    return n - es + 3;
  endfunction

  localparam int unsigned PA_N  = 8;
  localparam int unsigned PA_ES = 4;
  localparam int unsigned PA_EW = calc_ew(PA_N, PA_ES);
  localparam int unsigned PA_MW = calc_mw(PA_N, PA_ES);

  typedef struct packed {
    logic             sin;
    logic [PA_EW-1:0] eff_e;
    logic [PA_MW-1:0] mant;
    logic             zero;
    logic             nar;
  } posit_fields_t;

  typedef struct packed {
    logic             sign;
    logic             op_sub;
    logic [PA_EW-1:0] l_e;
    logic [PA_MW-1:0] l_mant;
    logic [PA_MW-1:0] s_mant;
    logic             sticky;
    logic             zero;
    logic             nar;
  } stage1_t;

endpackage

// File: rtl/posit_lzc.sv
// Combinational leading-zero counter; an all-zero input returns W.
module posit_lzc
  import posit_add_pkg::*;
#(
  parameter int unsigned W  = 7,
  parameter int unsigned CW = clog2(W + 1)
) (
  input  logic [W-1:0]  in_vec,
  output logic [CW-1:0] count
);

  always_comb begin
    count = CW'(W);
    for (int unsigned i = 0; i < W; i++) begin
      if (in_vec[i]) count = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/posit_align_add.sv
// Two-stage posit align/add/normalise core with valid/ready on both sides.
// Optional macro POSIT_ADD_STICKY_EN enables sticky tracking through both stages.
module posit_align_add
  import posit_add_pkg::*;
#(
  parameter int unsigned N  = PA_N,
  parameter int unsigned es = PA_ES,
  localparam int unsigned EW = calc_ew(N, es),
  localparam int unsigned MW = calc_mw(N, es)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          a_sin,
  input  logic          b_sin,
  input  logic [EW-1:0] a_eff_e,
  input  logic [EW-1:0] b_eff_e,
  input  logic [MW-1:0] a_mant,
  input  logic [MW-1:0] b_mant,
  input  logic          a_zero,
  input  logic          b_zero,
  input  logic          a_nar,
  input  logic          b_nar,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic [EW+1:0] out_eff_e,
  output logic [MW-1:0] out_mant,
  output logic          out_sticky,
  output logic          out_zero,
  output logic          out_nar
);

  localparam int unsigned CW = clog2(MW + 1);

  posit_fields_t a_f, b_f;
  logic          a_ge_b, l_sin;
  logic [EW-1:0] l_e, s_e;
  logic [MW-1:0] l_mant, s_mant;
  logic [EW:0]   diff, shamt;
  logic [2*MW:0] s_wide;

  stage1_t s1_d, s1_q;
  logic    s1_valid_d, s1_valid_q;
  logic    s1_adv, s2_adv;

  logic [MW:0]   sum;
  logic [CW-1:0] lz;
  logic [EW+1:0] e_ext, norm_e;
  logic [MW-1:0] norm_mant;
  logic          norm_sticky, sum_zero;

  logic          out_valid_d, out_valid_q;
  logic          out_sign_d, out_sign_q;
  logic [EW+1:0] out_eff_e_d, out_eff_e_q;
  logic [MW-1:0] out_mant_d, out_mant_q;
  logic          out_sticky_d, out_sticky_q;
  logic          out_zero_d, out_zero_q;
  logic          out_nar_d, out_nar_q;

  always_comb begin
    s2_adv   = !out_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = s1_adv;
  end

  always_comb begin
    a_f = '{sin: a_sin, eff_e: a_eff_e, mant: a_mant, zero: a_zero, nar: a_nar};
    b_f = '{sin: b_sin, eff_e: b_eff_e, mant: b_mant, zero: b_zero, nar: b_nar};
    // Flipping the exponent sign bit turns the signed (eff_e, mant) order into a plain unsigned compare.
    a_ge_b = {~a_f.eff_e[EW-1], a_f.eff_e[EW-2:0], a_f.mant} >=
             {~b_f.eff_e[EW-1], b_f.eff_e[EW-2:0], b_f.mant};
    l_sin  = a_ge_b ? a_f.sin   : b_f.sin;
    l_e    = a_ge_b ? a_f.eff_e : b_f.eff_e;
    l_mant = a_ge_b ? a_f.mant  : b_f.mant;
    s_e    = a_ge_b ? b_f.eff_e : a_f.eff_e;
    s_mant = a_ge_b ? b_f.mant  : a_f.mant;
    diff   = {l_e[EW-1], l_e} - {s_e[EW-1], s_e};
    shamt  = (diff > (EW+1)'(MW + 1)) ? (EW+1)'(MW + 1) : diff;
    s_wide = {s_mant, {(MW+1){1'b0}}} >> shamt;

    s1_d        = '0;
    s1_d.sign   = l_sin;
    s1_d.op_sub = a_f.sin ^ b_f.sin;
    s1_d.l_e    = l_e;
    s1_d.l_mant = l_mant;
    s1_d.s_mant = s_wide[2*MW:MW+1];
`ifdef POSIT_ADD_STICKY_EN
    s1_d.sticky = |s_wide[MW:0];
`endif
    if (a_f.nar || b_f.nar) begin
      s1_d     = '0;
      s1_d.nar = 1'b1;
    end else if (a_f.zero && b_f.zero) begin
      s1_d      = '0;
      s1_d.zero = 1'b1;
    end else if (a_f.zero || b_f.zero) begin
      // Adding zero to the surviving operand passes it through stage 2 untouched.
      s1_d        = '0;
      s1_d.sign   = a_f.zero ? b_f.sin   : a_f.sin;
      s1_d.l_e    = a_f.zero ? b_f.eff_e : a_f.eff_e;
      s1_d.l_mant = a_f.zero ? b_f.mant  : a_f.mant;
    end

    s1_valid_d = s1_valid_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
    end else begin
      s1_d = s1_q;
    end
  end

  posit_lzc #(.W(MW), .CW(CW)) u_lzc (
    .in_vec (sum[MW-1:0]),
    .count  (lz)
  );

  always_comb begin
    sum = s1_q.op_sub ? ({1'b0, s1_q.l_mant} - {1'b0, s1_q.s_mant})
                      : ({1'b0, s1_q.l_mant} + {1'b0, s1_q.s_mant});
    e_ext       = {{2{s1_q.l_e[EW-1]}}, s1_q.l_e};
    norm_sticky = s1_q.sticky;
    if (sum[MW]) begin
      norm_mant = sum[MW:1];
      norm_e    = e_ext + (EW+2)'(1);
`ifdef POSIT_ADD_STICKY_EN
      norm_sticky = s1_q.sticky | sum[0];
`endif
    end else begin
      norm_mant = sum[MW-1:0] << lz;
      norm_e    = e_ext - (EW+2)'(lz);
    end
`ifdef POSIT_ADD_STICKY_EN
    sum_zero = (sum == '0) && !s1_q.sticky;
`else
    sum_zero = (sum == '0);
`endif
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_sign_d   = out_sign_q;
    out_eff_e_d  = out_eff_e_q;
    out_mant_d   = out_mant_q;
    out_sticky_d = out_sticky_q;
    out_zero_d   = out_zero_q;
    out_nar_d    = out_nar_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_sign_d   = 1'b0;
        out_eff_e_d  = '0;
        out_mant_d   = '0;
        out_sticky_d = 1'b0;
        out_zero_d   = 1'b0;
        out_nar_d    = 1'b0;
        if (s1_q.nar) begin
          out_nar_d = 1'b1;
        end else if (s1_q.zero || sum_zero) begin
          out_zero_d = 1'b1;
        end else begin
          out_sign_d   = s1_q.sign;
          out_eff_e_d  = norm_e;
          out_mant_d   = norm_mant;
          out_sticky_d = norm_sticky;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_q         <= '0;
      out_valid_q  <= 1'b0;
      out_sign_q   <= 1'b0;
      out_eff_e_q  <= '0;
      out_mant_q   <= '0;
      out_sticky_q <= 1'b0;
      out_zero_q   <= 1'b0;
      out_nar_q    <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_q         <= s1_d;
      out_valid_q  <= out_valid_d;
      out_sign_q   <= out_sign_d;
      out_eff_e_q  <= out_eff_e_d;
      out_mant_q   <= out_mant_d;
      out_sticky_q <= out_sticky_d;
      out_zero_q   <= out_zero_d;
      out_nar_q    <= out_nar_d;
    end
  end

  always_comb begin
    out_valid  = out_valid_q;
    out_sign   = out_sign_q;
    out_eff_e  = out_eff_e_q;
    out_mant   = out_mant_q;
    out_sticky = out_sticky_q;
    out_zero   = out_zero_q;
    out_nar    = out_nar_q;
  end

endmodule

// File: tb/tb_posit_align_add.sv
// Scoreboard bench for posit_align_add (N=8, es=4): expectations queued at accept, checked at output.
module tb_posit_align_add;

  localparam int unsigned EW = 8;
  localparam int unsigned MW = 7;
  localparam int unsigned OW = 10;
`ifdef POSIT_ADD_STICKY_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  typedef struct packed {
    logic sin; logic [EW-1:0] e; logic [MW-1:0] mant; logic zero; logic nar;
  } op_t;
  typedef struct packed {
    logic sign; logic [OW-1:0] e; logic [MW-1:0] mant; logic sticky; logic zero; logic nar;
  } exp_t;

  logic clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic a_sin, b_sin, a_zero, b_zero, a_nar, b_nar;
  logic [EW-1:0] a_eff_e, b_eff_e;
  logic [MW-1:0] a_mant, b_mant, out_mant;
  logic [OW-1:0] out_eff_e;
  logic out_sign, out_sticky, out_zero, out_nar;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  posit_align_add #(.N(8), .es(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_sin(a_sin), .b_sin(b_sin), .a_eff_e(a_eff_e), .b_eff_e(b_eff_e),
    .a_mant(a_mant), .b_mant(b_mant), .a_zero(a_zero), .b_zero(b_zero),
    .a_nar(a_nar), .b_nar(b_nar), .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_eff_e(out_eff_e), .out_mant(out_mant),
    .out_sticky(out_sticky), .out_zero(out_zero), .out_nar(out_nar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [MW-1:0] ONE = 7'b1000000;
  localparam exp_t EXP_ZERO = '{sign: 1'b0, e: '0, mant: '0, sticky: 1'b0, zero: 1'b1, nar: 1'b0};
  localparam exp_t EXP_NAR  = '{sign: 1'b0, e: '0, mant: '0, sticky: 1'b0, zero: 1'b0, nar: 1'b1};

  function automatic op_t mk_op(input logic s, input int e, input logic [MW-1:0] m);
    op_t o;
    o = '{sin: s, e: EW'(e), mant: m, zero: 1'b0, nar: 1'b0};
    return o;
  endfunction

  function automatic exp_t mk_exp(input logic s, input int e, input logic [MW-1:0] m, input logic st);
    exp_t x;
    x = '{sign: s, e: OW'(e), mant: m, sticky: st, zero: 1'b0, nar: 1'b0};
    return x;
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    o = '{sin: 1'($urandom), e: EW'($urandom), mant: MW'($urandom), zero: 1'b0, nar: 1'b0};
    return o;
  endfunction

  // Presents one pair, holds it until accepted, then queues its expected result.
  task automatic send(input op_t a, input op_t b, input exp_t ex);
    logic acc;
    int unsigned g;
    a_sin = a.sin; a_eff_e = a.e; a_mant = a.mant; a_zero = a.zero; a_nar = a.nar;
    b_sin = b.sin; b_eff_e = b.e; b_mant = b.mant; b_zero = b.zero; b_nar = b.nar;
    in_valid = 1'b1;
    acc = 1'b0;
    g = 0;
    while (!acc && g < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      g++;
    end
    if (acc) exp_q.push_back(ex);
    else begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_ready=0 required=1");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_sign, out_eff_e, out_mant, out_sticky, out_zero, out_nar} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0",
               {out_valid, out_sign, out_eff_e, out_mant, out_sticky, out_zero, out_nar});
    end
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release: in_ready,out_valid=%b required 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_arith();
    op_t  ta[11], tbo[11];
    exp_t te[11];
    exp_t got, ex;
    int unsigned g;
    ta[0]  = mk_op(0, 0, ONE);        tbo[0]  = mk_op(0, 0, ONE);        te[0]  = mk_exp(0, 1, ONE, 0);
    ta[1]  = mk_op(0, 2, ONE);        tbo[1]  = mk_op(0, 0, ONE);        te[1]  = mk_exp(0, 2, 7'b1010000, 0);
    ta[2]  = mk_op(0, 0, ONE);        tbo[2]  = mk_op(0, 2, ONE);        te[2]  = mk_exp(0, 2, 7'b1010000, 0);
    ta[3]  = mk_op(0, 0, ONE);        tbo[3]  = mk_op(1, 0, ONE);        te[3]  = EXP_ZERO;
    ta[4]  = mk_op(0, 0, 7'b1100000); tbo[4]  = mk_op(1, 0, ONE);        te[4]  = mk_exp(0, -1, ONE, 0);
    ta[5]  = mk_op(1, 20, ONE);       tbo[5]  = mk_op(0, 0, ONE);        te[5]  = mk_exp(1, 20, ONE, STK);
    ta[6]  = mk_op(1, 0, ONE);        tbo[6]  = mk_op(1, 0, ONE);        te[6]  = mk_exp(1, 1, ONE, 0);
    ta[7]  = mk_op(0, 0, 7'b1000001); tbo[7]  = mk_op(0, 0, ONE);        te[7]  = mk_exp(0, 1, ONE, STK);
    ta[8]  = mk_op(0, 0, ONE);        tbo[8]  = mk_op(0, -3, 7'b1000001); te[8] = mk_exp(0, 0, 7'b1001000, STK);
    ta[9]  = mk_op(0, 8, ONE);        tbo[9]  = mk_op(0, 0, 7'b1100000); te[9]  = mk_exp(0, 8, ONE, STK);
    ta[10] = mk_op(0, 2, ONE);        tbo[10] = mk_op(1, 0, ONE);        te[10] = mk_exp(0, 1, 7'b1100000, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      send(ta[i], tbo[i], te[i]);
      in_valid = 1'b0;
      if (i == 0) begin
        n_checks++;
        if (out_valid !== 1'b0) begin
          n_fail++; $display("FAIL latency_early: out_valid=%b required 0", out_valid);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1) begin
          n_fail++; $display("FAIL latency_two: out_valid=%b required 1", out_valid);
        end
      end
      g = 0;
      while (!out_valid && g < 20) begin @(posedge clk); #1; g++; end
      n_checks++;
      if (!out_valid) begin
        n_fail++; $display("FAIL arith_timeout[%0d]: out_valid=0 required 1", i);
      end else begin
        ex  = exp_q.pop_front();
        got = {out_sign, out_eff_e, out_mant, out_sticky, out_zero, out_nar};
        if (got !== ex) begin
          n_fail++; $display("FAIL arith[%0d]: got %h required %h", i, got, ex);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_specials();
    op_t  sa[5], sb[5];
    exp_t se[5];
    exp_t got, ex;
    int unsigned g;
    sa[0] = rnd_op();  sa[0].nar = 1'b1; sb[0] = rnd_op();  se[0] = EXP_NAR;
    sa[1] = rnd_op();  sb[1] = rnd_op(); sb[1].nar = 1'b1;  se[1] = EXP_NAR;
    sa[2] = mk_op(1, -3, 7'b1011000); sb[2] = rnd_op(); sb[2].zero = 1'b1;
    se[2] = mk_exp(1, -3, 7'b1011000, 0);
    sa[3] = rnd_op();  sa[3].zero = 1'b1; sb[3] = mk_op(0, 5, 7'b1110000);
    se[3] = mk_exp(0, 5, 7'b1110000, 0);
    sa[4] = rnd_op();  sa[4].zero = 1'b1; sb[4] = rnd_op(); sb[4].zero = 1'b1; se[4] = EXP_ZERO;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(sa[i], sb[i], se[i]);
      in_valid = 1'b0;
      g = 0;
      while (!out_valid && g < 20) begin @(posedge clk); #1; g++; end
      n_checks++;
      if (!out_valid) begin
        n_fail++; $display("FAIL special_timeout[%0d]: out_valid=0 required 1", i);
      end else begin
        ex  = exp_q.pop_front();
        got = {out_sign, out_eff_e, out_mant, out_sticky, out_zero, out_nar};
        if (got !== ex) begin
          n_fail++; $display("FAIL special[%0d]: got %h required %h", i, got, ex);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned extra;
    out_ready = 1'b0;
    fork
      begin
        send(mk_op(0, 0, ONE), mk_op(0, 0, ONE), mk_exp(0, 1, ONE, 0));
        send(mk_op(0, 2, ONE), mk_op(0, 0, ONE), mk_exp(0, 2, 7'b1010000, 0));
        send(mk_op(0, 0, 7'b1100000), mk_op(1, 0, ONE), mk_exp(0, -1, ONE, 0));
        send(mk_op(1, 20, ONE), mk_op(0, 0, ONE), mk_exp(1, 20, ONE, STK));
        in_valid = 1'b0;
      end
      begin
        exp_t got;
        int unsigned cyc, got_n;
        cyc = 0; got_n = 0;
        while (got_n < 4 && cyc < 60) begin
          out_ready = (cyc >= 5);
          @(negedge clk);
          if (cyc == 2) begin
            n_checks++;
            if ({in_ready, out_valid} !== 2'b01) begin
              n_fail++; $display("FAIL bp_full: in_ready,out_valid=%b required 01", {in_ready, out_valid});
            end
          end
          if (out_valid) begin
            got = {out_sign, out_eff_e, out_mant, out_sticky, out_zero, out_nar};
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++; $display("FAIL bp_extra: got %h required none", got);
            end else if (got !== exp_q[0]) begin
              n_fail++; $display("FAIL bp_data[%0d]: got %h required %h", got_n, got, exp_q[0]);
            end
            if (out_ready && exp_q.size() != 0) begin
              void'(exp_q.pop_front());
              got_n++;
            end
          end
          @(posedge clk); #1;
          cyc++;
        end
        n_checks++;
        if (got_n != 4) begin
          n_fail++; $display("FAIL bp_count: got %0d required 4", got_n);
        end
      end
    join
    out_ready = 1'b1;
    extra = 0;
    for (int k = 0; k < 3; k++) begin
      if (out_valid) extra++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (extra != 0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL bp_dup: extra=%0d left=%0d required 0 0", extra, exp_q.size());
    end
  endtask

  task automatic test_reset_flight();
    exp_t got, ex;
    int unsigned g, seen;
    out_ready = 1'b0;
    send(mk_op(0, 0, ONE), mk_op(0, 0, ONE), mk_exp(0, 1, ONE, 0));
    send(mk_op(0, 2, ONE), mk_op(0, 0, ONE), mk_exp(0, 2, 7'b1010000, 0));
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_sign, out_eff_e, out_mant, out_sticky, out_zero, out_nar} !== '0) begin
      n_fail++;
      $display("FAIL flight_reset: got %h required 0",
               {out_valid, out_sign, out_eff_e, out_mant, out_sticky, out_zero, out_nar});
    end
    exp_q.delete();
    #13 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL flight_ghost: out_valid cycles=%0d required 0", seen);
    end
    send(mk_op(0, 2, ONE), mk_op(1, 0, ONE), mk_exp(0, 1, 7'b1100000, 0));
    in_valid = 1'b0;
    g = 0;
    while (!out_valid && g < 20) begin @(posedge clk); #1; g++; end
    n_checks++;
    if (!out_valid) begin
      n_fail++; $display("FAIL flight_timeout: out_valid=0 required 1");
    end else begin
      ex  = exp_q.pop_front();
      got = {out_sign, out_eff_e, out_mant, out_sticky, out_zero, out_nar};
      if (got !== ex) begin
        n_fail++; $display("FAIL flight_after: got %h required %h", got, ex);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    {a_sin, b_sin, a_zero, b_zero, a_nar, b_nar} = '0;
    a_eff_e = '0; b_eff_e = '0; a_mant = '0; b_mant = '0;
    test_reset();
    test_arith();
    test_specials();
    test_back_to_back();
    test_reset_flight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
